outer_loop_ctrl: RTL and testbench

Sequencer for the `inner_loop_new` 3072×78 partial-product datapath. It digit-serially walks a captured 3072-bit multiplier operand B, least-significant 78-bit digit first. For each digit it presents the digit and an enable pulse to the inner loop, waits for the inner loop's completion level, then hands the r0/r1 carry-save result to the downstream accumulator over a valid/ready handshake. It sits between the top-level multiply FSM and the inner loop / accumulator pair.

---
 rtl/outer_loop_ctrl.sv | 95 +++++++++
 tb/tb_outer_loop_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/outer_loop_ctrl.sv
// outer_loop_ctrl: digit-serial sequencer feeding B digits to the inner loop and handing results to the accumulator
module outer_loop_ctrl #(
  parameter int Size    = 3072,
  parameter int radix   = 78,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Size-1:0]  b,
  output logic             busy,
  output logic [radix-1:0] ip_bi,
  output logic             ip_en,
  input  logic             ip_done,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             acc_first,
  output logic [5:0]       digit_idx,
  output logic             done,
  output logic             error
);
  localparam int digits = (Size + radix - 1) / radix;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [5:0] LAST_IDX = 6'(digits - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [Size-1:0] breg_q, breg_d;
  logic [radix-1:0] ip_bi_q, ip_bi_d;
  logic [5:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      breg_q  <= '0;
      ip_bi_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      breg_q  <= breg_d;
      ip_bi_q <= ip_bi_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    breg_d  = breg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        breg_d  = b;
        idx_d   = '0;
        err_d   = 1'b0;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (ip_done) state_d = ACC;
        else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      ACC: if (acc_ready) begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else begin
          state_d = ISSUE;
          breg_d  = breg_q >> radix;
          idx_d   = idx_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // the digit register loads on entry to ISSUE and then stays frozen through ACC
    ip_bi_d = (state_d == ISSUE) ? breg_d[radix-1:0] : ip_bi_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    ip_en     = state_q == ISSUE;
    acc_valid = state_q == ACC;
    acc_first = (state_q == ACC) && (idx_q == '0);
    done      = state_q == DONE;
    ip_bi     = ip_bi_q;
    digit_idx = idx_q;
    error     = err_q;
  end
endmodule

// File: tb/tb_outer_loop_ctrl.sv
// tb_outer_loop_ctrl: directed checks of outer_loop_ctrl against a 4-cycle inner-loop model
module tb_outer_loop_ctrl;
  logic clk = 0, rst = 1, start = 0, ip_done = 0, acc_ready = 1;
  logic [3071:0] b = '0;
  logic busy, ip_en, acc_valid, acc_first, done, error;
  logic [77:0] ip_bi;
  logic [5:0] digit_idx;
  int n_cmp = 0, n_err = 0;
  int hang_idx = -1, dly = 0;
  logic hang = 0;
  logic [77:0] bi_seen [40];
  int en_t [40];
  int n_en, first_cnt, first_idx, done_t, busy_cnt, valid5, stall_idx, stall_left;

  outer_loop_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .b(b), .busy(busy), .ip_bi(ip_bi),
    .ip_en(ip_en), .ip_done(ip_done), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_first(acc_first), .digit_idx(digit_idx), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // inner loop: en_out drops after the enable, rises 4 cycles after ISSUE unless hung
  always @(posedge clk) begin
    if (ip_en) begin
      dly <= 1;
      ip_done <= 1'b0;
      hang <= (int'(digit_idx) == hang_idx);
    end else if (dly > 0 && dly < 4) begin
      dly <= dly + 1;
      if (dly == 3 && !hang) ip_done <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [3071:0] val);
    b = val;
    start = 1;
    tick();
    start = 0;
  endtask

  // walk from the current ISSUE cycle until busy falls or the cycle budget runs out
  task automatic observe(input int max_cyc);
    int cyc = 0;
    n_en = 0; first_cnt = 0; first_idx = -1; done_t = -1; busy_cnt = 0; valid5 = 0;
    for (int i = 0; i < 40; i++) begin bi_seen[i] = 'x; en_t[i] = -1; end
    while (cyc < max_cyc) begin
      if (!busy && cyc > 0) break;
      if (busy) busy_cnt++;
      if (ip_en) begin
        if (n_en < 40) begin bi_seen[n_en] = ip_bi; en_t[n_en] = cyc; end
        n_en++;
      end
      if (acc_valid && acc_first) begin first_cnt++; first_idx = int'(digit_idx); end
      if (acc_valid && digit_idx == 6'd5) valid5++;
      if (done) done_t = cyc;
      if (acc_valid && int'(digit_idx) == stall_idx && stall_left > 0) begin
        acc_ready = 0;
        stall_left--;
      end else acc_ready = 1;
      tick();
      cyc++;
    end
  endtask

  initial begin
    logic [3071:0] hi;
    int nz, gaps;
    stall_idx = -1; stall_left = 0;
    rst = 1; start = 1; b = 3072'h1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ip_en", ip_en, 0);
    chk("rst_ip_bi", ip_bi, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_first", acc_first, 0);
    chk("rst_digit_idx", digit_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 0;
    tick();
    start = 0;
    chk("first_issue_en", ip_en, 1);
    chk("first_issue_busy", busy, 1);
    observe(400);
    chk("b1_bi0", bi_seen[0], 78'h1);
    nz = 0; gaps = 0;
    for (int i = 1; i < 40; i++) begin
      if (bi_seen[i] !== 78'h0) nz++;
      if (en_t[i] - en_t[i-1] != 6) gaps++;
    end
    chk("b1_nonzero_digits", nz, 0);
    chk("b1_en_gap_not6", gaps, 0);
    chk("b1_n_en", n_en, 40);
    chk("b1_first_cnt", first_cnt, 1);
    chk("b1_first_idx", first_idx, 0);
    chk("b1_done_t", done_t, 240);
    chk("b1_busy_cnt", busy_cnt, 241);
    chk("b1_error", error, 0);

    hi = '0;
    hi[3071:3042] = '1;
    start_op(hi);
    observe(400);
    nz = 0;
    for (int i = 0; i < 39; i++) if (bi_seen[i] !== 78'h0) nz++;
    chk("hi_low_digits_nonzero", nz, 0);
    chk("hi_digit39", bi_seen[39], 78'h0000_0000_0000_3FFF_FFFF);
    chk("hi_done_t", done_t, 240);

    stall_idx = 5; stall_left = 10;
    start_op(3072'h5);
    observe(400);
    stall_idx = -1;
    chk("stall_valid5", valid5, 11);
    chk("stall_en_gap", en_t[6] - en_t[5], 16);
    chk("stall_done_t", done_t, 250);
    chk("stall_busy_cnt", busy_cnt, 251);

    hang_idx = 3;
    start_op(3072'h7);
    observe(400);
    hang_idx = -1;
    chk("to_error", error, 1);
    chk("to_busy_cnt", busy_cnt, 27);
    chk("to_no_done", done_t, -1);
    chk("to_n_en", n_en, 4);
    chk("to_idle", busy, 0);
    start_op(3072'h1);
    chk("to_start_clears_error", error, 0);
    chk("to_restart_en", ip_en, 1);

    tick();
    rst = 1;
    tick();
    rst = 0;
    start_op(3072'h1);
    observe(122);
    chk("mid_n_en", n_en, 21);
    chk("mid_in_wait_idx", digit_idx, 20);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", digit_idx, 0);
    chk("mid_rst_done", done, 0);
    start_op(3072'h9);
    observe(400);
    chk("fresh_busy_cnt", busy_cnt, 241);
    chk("fresh_done_t", done_t, 240);
    chk("fresh_bi0", bi_seen[0], 78'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
